// File: rtl/mips16_pkg.sv
// mips16_pkg -- shared constants and types for the MIPS16 fetch stage.
//   ADDR_W / INSTR_W : word-address and instruction widths
//   RESET_PC         : PC value held while reset is asserted
//   ISR_VECTOR       : handler entry address loaded when an interrupt is taken
//   NOP_INSTR        : instruction word used for IF/ID bubbles
//   int_state_e      : interrupt controller state encoding
package mips16_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0]  RESET_PC   = 16'h0000;
    localparam logic [ADDR_W-1:0]  ISR_VECTOR = 16'h0010;
    localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        TAKE = 2'b01,
        ISR  = 2'b10
    } int_state_e;

endpackage

// File: rtl/if_int_ctrl.sv
// if_int_ctrl -- interrupt sequencing for the fetch stage; owns the FSM and epc.
//
// Build option: IF_INTERRUPT_EN. When undefined the controller is absent,
// every request output is tied low, epc_o reads 16'h0000 and in_isr_o reads 0.
//
// Ports
//   clk, reset      : clock, asynchronous active-high reset
//   interrupt_i     : level interrupt request
//   branch_taken_i  : execute-stage redirect (always outranks the interrupt path)
//   eret_i          : return-from-interrupt pulse
//   pc_i            : current architectural PC
//   int_req_o       : request accepted this cycle; fetch holds PC and bubbles
//   take_o          : TAKE state; fetch loads ISR_VECTOR
//   ret_o           : eret honoured this cycle; fetch loads epc
//   epc_o           : saved return address
//   in_isr_o        : handler executing
//
// state | meaning
// IDLE  | normal fetch, watching for an interrupt request
// TAKE  | one cycle: save PC into epc, redirect fetch to ISR_VECTOR
// ISR   | handler running, further requests ignored until eret
module if_int_ctrl
    import mips16_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              interrupt_i,
    input  logic              branch_taken_i,
    input  logic              eret_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              int_req_o,
    output logic              take_o,
    output logic              ret_o,
    output logic [ADDR_W-1:0] epc_o,
    output logic              in_isr_o
);

`ifdef IF_INTERRUPT_EN
    int_state_e        state_q;
    logic [ADDR_W-1:0] epc_q;
    logic              in_isr_q;

    // A branch arriving in TAKE keeps the FSM in TAKE so that epc captures the
    // branch target on the following cycle instead of a discarded address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            epc_q    <= RESET_PC;
            in_isr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (interrupt_i && !branch_taken_i) begin
                        state_q <= TAKE;
                    end
                end
                TAKE: begin
                    if (!branch_taken_i) begin
                        epc_q    <= pc_i;
                        in_isr_q <= 1'b1;
                        state_q  <= ISR;
                    end
                end
                ISR: begin
                    if (eret_i && !branch_taken_i) begin
                        in_isr_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    in_isr_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    // Accepting the request holds the PC for one cycle so the instruction at
    // pc_i is not issued; TAKE then records that same address as epc.
    assign int_req_o = (state_q == IDLE) && interrupt_i && !branch_taken_i;
    assign take_o    = (state_q == TAKE);
    assign ret_o     = (state_q == ISR) && eret_i && !branch_taken_i;
    assign epc_o     = epc_q;
    assign in_isr_o  = in_isr_q;
`else
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, interrupt_i, branch_taken_i, eret_i, pc_i};

    assign int_req_o = 1'b0;
    assign take_o    = 1'b0;
    assign ret_o     = 1'b0;
    assign epc_o     = RESET_PC;
    assign in_isr_o  = 1'b0;
`endif

endmodule

// File: rtl/if_stage.sv
// if_stage -- instruction fetch: PC register, next-PC mux and IF/ID register.
//
// Build option: IF_INTERRUPT_EN enables interrupt entry/return through
// if_int_ctrl; without it interrupt and eret are ignored.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   interrupt         : level interrupt request
//   stall             : decode hazard hold (freezes PC and IF/ID)
//   branch_taken      : redirect from execute
//   branch_target     : redirect word address
//   eret              : return-from-interrupt pulse
//   imem_data         : instruction word at imem_addr (combinational memory)
//   imem_addr         : fetch address, equals current_address
//   current_address   : architectural PC
//   ins, pc_id        : IF/ID instruction and its PC
//   valid_id          : ins is a real instruction (0 = bubble)
//   epc, in_isr       : saved return address, handler active
module if_stage
    import mips16_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               interrupt,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               eret,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [ADDR_W-1:0]  current_address,
    output logic [INSTR_W-1:0] ins,
    output logic [ADDR_W-1:0]  pc_id,
    output logic               valid_id,
    output logic [ADDR_W-1:0]  epc,
    output logic               in_isr
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ins_q, ins_d;
    logic [ADDR_W-1:0]  pc_id_q, pc_id_d;
    logic               valid_q, valid_d;

    logic              int_req;
    logic              take;
    logic              ret;
    logic [ADDR_W-1:0] epc_w;

    if_int_ctrl u_int_ctrl (
        .clk            (clk),
        .reset          (reset),
        .interrupt_i    (interrupt),
        .branch_taken_i (branch_taken),
        .eret_i         (eret),
        .pc_i           (pc_q),
        .int_req_o      (int_req),
        .take_o         (take),
        .ret_o          (ret),
        .epc_o          (epc_w),
        .in_isr_o       (in_isr)
    );

    // Bubbles clear pc_id as well so a bubble always reads as all-zero IF/ID.
    always_comb begin
        pc_d    = pc_q;
        ins_d   = ins_q;
        pc_id_d = pc_id_q;
        valid_d = valid_q;
        if (branch_taken) begin
            pc_d    = branch_target;
            ins_d   = NOP_INSTR;
            pc_id_d = RESET_PC;
            valid_d = 1'b0;
        end else if (take) begin
            pc_d    = ISR_VECTOR;
            ins_d   = NOP_INSTR;
            pc_id_d = RESET_PC;
            valid_d = 1'b0;
        end else if (ret) begin
            pc_d    = epc_w;
            ins_d   = NOP_INSTR;
            pc_id_d = RESET_PC;
            valid_d = 1'b0;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (int_req) begin
            ins_d   = NOP_INSTR;
            pc_id_d = RESET_PC;
            valid_d = 1'b0;
        end else begin
            pc_d    = pc_q + ADDR_W'(1);
            ins_d   = imem_data;
            pc_id_d = pc_q;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            ins_q   <= NOP_INSTR;
            pc_id_q <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            pc_id_q <= pc_id_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr       = pc_q;
    assign current_address = pc_q;
    assign ins             = ins_q;
    assign pc_id           = pc_id_q;
    assign valid_id        = valid_q;
    assign epc             = epc_w;

endmodule
